// File: rtl/muldiv_controller.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiplier and restoring divider
// iterating on operand magnitudes, with a one-cycle fast path for divide-by-zero and overflow.
module muldiv_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  result_valid_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [1:0]      op;
    logic            neg;
    logic [W-1:0]    operand;
    logic [2*W-1:0]  acc;

    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_path;
    logic            neg_issue;
    logic [W-1:0]    abs_a;
    logic [W-1:0]    abs_b;
    logic [W-1:0]    special_result;

    // Issue-time decode; remainders take the dividend's sign, everything else the XOR of signs.
    always_comb begin
        a_signed  = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
        b_signed  = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
        sign_a    = a_signed && op_a_i[W-1];
        sign_b    = b_signed && op_b_i[W-1];
        abs_a     = sign_a ? -op_a_i : op_a_i;
        abs_b     = sign_b ? -op_b_i : op_b_i;
        div_zero  = (op_b_i == '0);
        div_ovf   = !funct3_i[0] && (op_a_i == MIN_INT) && (op_b_i == '1);
        fast_path = funct3_i[2] && (div_zero || div_ovf);
        neg_issue = (funct3_i[2] && funct3_i[1]) ? sign_a : (sign_a ^ sign_b);
        if (funct3_i[1]) begin
            special_result = div_zero ? op_a_i : '0;
        end else begin
            special_result = div_zero ? '1 : MIN_INT;
        end
    end

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [2*W-1:0]  mul_prod;
    logic [W-1:0]    mul_res;
    logic [W:0]      div_top;
    logic            div_ge;
    logic [W-1:0]    div_rem;
    logic [2*W-1:0]  div_next;
    logic [W-1:0]    quot;
    logic [W-1:0]    rem;
    logic [W-1:0]    div_res;

    // Multiply keeps the multiplier in acc's low half; divide keeps {remainder, dividend}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[W-1:1]};
        mul_prod = neg ? -mul_next : mul_next;
        mul_res  = (op == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];

        div_top  = acc[2*W-1:W-1];
        div_ge   = (div_top >= {1'b0, operand});
        div_rem  = div_ge ? (div_top[W-1:0] - operand) : div_top[W-1:0];
        div_next = {div_rem, acc[W-2:0], div_ge};
        quot     = div_next[W-1:0];
        rem      = div_next[2*W-1:W];
        if (op[1]) begin
            div_res = neg ? -rem : rem;
        end else begin
            div_res = neg ? -quot : quot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            op       <= '0;
            neg      <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            result_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op    <= funct3_i[1:0];
                        neg   <= neg_issue;
                        count <= CW'(DATA_WIDTH - 1);
                        if (!funct3_i[2]) begin
                            acc     <= {{W{1'b0}}, abs_b};
                            operand <= abs_a;
                            state   <= MUL;
                        end else if (fast_path) begin
                            result_o <= special_result;
                            state    <= DONE;
                        end else begin
                            acc     <= {{W{1'b0}}, abs_a};
                            operand <= abs_b;
                            state   <= DIV;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result_o <= mul_res;
                        state    <= DONE;
                    end
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result_o <= div_res;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_o        = ((state == IDLE && start_i) || state == MUL || state == DIV) && !flush_i;
    assign busy_o         = (state != IDLE);
    assign result_valid_o = (state == DONE) && !flush_i;

endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Sequencing controller for the RV32M multiply/divide operations in the EX stage of the RV32IMA pipeline. It accepts one M-extension operation per issue. It runs an internal radix-2 shift-add multiplier or restoring divider for a fixed number of cycles, and holds the pipeline with `stall_o` until the result is ready. It returns the result to the EX/MEM path, where it is forwarded like any ALU result. Divide-by-zero and signed-overflow cases take a single-cycle fast path.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width. Only 32 is supported; the iteration count equals `DATA_WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start_i`  in  1  EX stage holds a valid M-op (opcode 0110011, funct7 0000001)
- `funct3_i`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a_i`  in  32  rs1 value, already forwarded
- `op_b_i`  in  32  rs2 value, already forwarded
- `flush_i`  in  1  kill the in-flight op (branch/exception flush of EX)
- `stall_o`  out  1  freeze IF/ID/EX and bubble MEM
- `busy_o`  out  1  FSM not IDLE
- `result_valid_o`  out  1  one-cycle pulse; `result_o` valid
- `result_o`  out  32  registered result; holds its value until the next completion

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On `start_i && !flush_i`, latch operands, funct3 and sign flags.
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 with `op_b_i`==0, or signed DIV/REM with a=0x80000000 and b=0xFFFFFFFF, goes to DONE with the special result.
  - Any other funct3[2]=1 op goes to DIV.
  - The iteration counter loads 31.
- Signed handling:
  - MUL/MULH: both operands are signed.
  - MULHSU: a is signed, b is unsigned.
  - DIV/REM: both operands are signed.
  - The datapath iterates on absolute values with a 64-bit accumulator. The sign is corrected in the final iteration before `result_o` is written.
  - Quotient sign is sign(a) XOR sign(b). Remainder sign is sign(a).
- MUL state: one shift-add per cycle. The counter decrements and the FSM goes to DONE after counter==0. MUL takes the low 32 bits of the 64-bit product; MULH/MULHSU/MULHU take the high 32 bits.
- DIV state: one restoring-division step per cycle. It goes to DONE after counter==0. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = a.
  - Overflow: quotient 0x80000000; remainder 0.
- DONE: `result_valid_o`=1 and `stall_o`=0, so the pipeline advances. DONE always goes to IDLE. `start_i` is ignored in DONE, because it still reflects the completing instruction.
- `flush_i`: from any state, the FSM goes to IDLE on the next edge and `stall_o` is forced to 0 in that cycle. `result_valid_o` is suppressed if `flush_i` is asserted in DONE. `result_o` is not updated by a flushed op.
- Reset gives: state IDLE, counter 0, `result_o`=0, `stall_o`=0, `busy_o`=0, `result_valid_o`=0.

## Timing
- `stall_o` = (IDLE && `start_i`) || MUL || DIV, gated by `!flush_i`. It is combinational from `start_i`, so the stall appears in the issue cycle T.
- Multiply/divide latency, with the op issued in cycle T:
  - T: accept.
  - T+1..T+32: iterations, `stall_o`=1 for 33 cycles total.
  - T+33: DONE.
- Fast path latency: T accept, T+1 DONE. `stall_o` is 1 only in T.
- `result_o` is written on the edge entering DONE. It is therefore valid in the DONE cycle and stays stable afterwards.
- `busy_o` is 1 in MUL, DIV and DONE, and 0 in IDLE.
- Back-to-back ops: a new `start_i` can be accepted in the IDLE cycle immediately after DONE, so there are no dead cycles beyond DONE.
- Reset wins over `flush_i` and `start_i` in the same cycle. Reset asserted mid-iteration discards the op; `result_valid_o` never pulses for it.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) at T:
  - `stall_o`=1 for T..T+32.
  - At T+33: `result_valid_o`=1, `result_o`=0xFFFFFFEB, `stall_o`=0.
- MULH a=b=0x80000000: `result_o`=0x40000000. MULHU with the same operands: 0x40000000. MULHSU a=0xFFFFFFFF, b=2: 0xFFFFFFFF.
- DIV a=-7, b=2: quotient 0xFFFFFFFD. REM with the same operands: 0xFFFFFFFF. DIVU a=100, b=7: 14, valid at T+33.
- DIVU a=0x1234, b=0: `result_o`=0xFFFFFFFF at T+1. REMU with the same operands: 0x1234. DIV a=0x80000000, b=0xFFFFFFFF: 0x80000000 at T+1. Each has `stall_o` high only in T.
- Flush mid-op:
  - Start DIV at T and assert `flush_i` at T+10.
  - Required: `stall_o`=0 at T+10, state IDLE at T+11, no `result_valid_o`, `result_o` unchanged.
  - A new MUL issued at T+11 completes at T+44.
- Reset at T+5 of a MUL: all outputs 0 at T+6 and no result pulse. An op issued immediately after reset completes normally.
